// File: rtl/pulse_pkg.sv
// Shared definitions for the multi-channel one-shot generator.
// This package holds the per-channel FSM state encoding used by pulse_channel.
package pulse_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'b00,
    ST_HIGH     = 2'b01,
    ST_WAIT_LOW = 2'b10
  } state_t;

endpackage

// File: rtl/pulse_channel.sv
// One one-shot channel: an optional input synchroniser, an edge register, the FSM and a
// pulse counter. A trigger loads a programmable length L, and the output stays high for L cycles.
module pulse_channel
  import pulse_pkg::*;
#(
  parameter int LEN_W       = 8,
  parameter int SYNC_STAGES = 0,
  parameter int RETRIGGER   = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             pulse_in,
  input  logic [LEN_W-1:0] pulse_len,
  input  logic             ch_enable,
  output logic             pulse_out,
  output logic             busy,
  output logic             done
);

  logic             w_s;
  logic             r_s_d;
  logic             w_rise;
  logic [LEN_W-1:0] w_len_trig;
  state_t           r_state;
  state_t           w_state_nxt;
  logic [LEN_W-1:0] r_cnt;
  logic [LEN_W-1:0] w_cnt_nxt;
  logic [LEN_W-1:0] r_len;
  logic [LEN_W-1:0] w_len_nxt;
  logic             r_pulse;
  logic             r_done;

  generate
    if (SYNC_STAGES == 0) begin : g_nosync
      assign w_s = pulse_in;
    end else begin : g_sync
      logic [SYNC_STAGES-1:0] r_sync;
      always_ff @(posedge clk) begin
        if (rst) begin
          r_sync <= '0;
        end else begin
          r_sync[0] <= pulse_in;
          for (int i = 1; i < SYNC_STAGES; i++) r_sync[i] <= r_sync[i-1];
        end
      end
      assign w_s = r_sync[SYNC_STAGES-1];
    end
  endgenerate

  assign w_rise     = w_s & ~r_s_d;
  // A programmed length of zero still produces a single-cycle pulse.
  assign w_len_trig = (pulse_len == '0) ? LEN_W'(1) : pulse_len;

  // NOTE: every output of always_comb gets a default first, so no path can infer a latch.
  always_comb begin
    w_state_nxt = ST_IDLE;
    w_cnt_nxt   = r_cnt;
    w_len_nxt   = r_len;
    case (r_state)
      ST_IDLE: begin
        if (w_s && ch_enable) begin
          w_state_nxt = ST_HIGH;
          w_cnt_nxt   = LEN_W'(1);
          w_len_nxt   = w_len_trig;
        end
      end
      ST_HIGH: begin
        if ((RETRIGGER != 0) && w_rise && ch_enable) begin
          w_state_nxt = ST_HIGH;
          w_cnt_nxt   = LEN_W'(1);
          w_len_nxt   = w_len_trig;
        end else if (r_cnt == r_len) begin
          w_state_nxt = w_s ? ST_WAIT_LOW : ST_IDLE;
        end else begin
          w_state_nxt = ST_HIGH;
          w_cnt_nxt   = r_cnt + LEN_W'(1);
        end
      end
      ST_WAIT_LOW: w_state_nxt = w_s ? ST_WAIT_LOW : ST_IDLE;
      default:     w_state_nxt = ST_IDLE;
    endcase
  end

  // Outputs are registered from the next state, so done marks the last high cycle.
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_len   <= '0;
      r_s_d   <= 1'b0;
      r_pulse <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_len   <= w_len_nxt;
      r_s_d   <= w_s;
      r_pulse <= (w_state_nxt == ST_HIGH);
      r_done  <= (w_state_nxt == ST_HIGH) && (w_cnt_nxt == w_len_nxt);
    end
  end

  assign pulse_out = r_pulse;
  assign busy      = r_pulse;
  assign done      = r_done;

endmodule

// File: rtl/multi_pulse_gen.sv
// Multi-channel one-shot generator. Each channel runs independently, and this top level
// only slices the buses into one pulse_channel instance per channel.
module multi_pulse_gen
  import pulse_pkg::*;
#(
  parameter int NUM_CH      = 4,
  parameter int LEN_W       = 8,
  parameter int SYNC_STAGES = 0,
  parameter int RETRIGGER   = 0
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_CH-1:0]       pulse_in,
  input  logic [NUM_CH*LEN_W-1:0] pulse_len,
  input  logic [NUM_CH-1:0]       ch_enable,
  output logic [NUM_CH-1:0]       pulse_out,
  output logic [NUM_CH-1:0]       busy,
  output logic [NUM_CH-1:0]       done
);

  generate
    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
      pulse_channel #(
        .LEN_W       (LEN_W),
        .SYNC_STAGES (SYNC_STAGES),
        .RETRIGGER   (RETRIGGER)
      ) u_ch (
        .clk       (clk),
        .rst       (rst),
        .pulse_in  (pulse_in[g]),
        .pulse_len (pulse_len[g*LEN_W +: LEN_W]),
        .ch_enable (ch_enable[g]),
        .pulse_out (pulse_out[g]),
        .busy      (busy[g]),
        .done      (done[g])
      );
    end
  endgenerate

endmodule
